result_bcd_display: RTL and testbench

Output stage placed directly downstream of the calculator top. On each single-cycle `Finish` pulse it captures the 16-bit `Result` and converts it to decimal with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It then drives a 6-digit, time-multiplexed, active-low seven-segment display with leading-zero blanking. The calculator core is not stalled; the block only observes `Finish` and `Result`.

---
 rtl/result_bcd_display_if.sv | 12 +
 rtl/result_bcd_display.sv | 141 ++++++++++++++
 tb/tb_result_bcd_display.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/result_bcd_display_if.sv
// Handshake bundle between the calculator top (master) and the BCD display stage (slave).
interface result_bcd_display_if;
  logic        Finish;
  logic [15:0] Result;
  logic [7:0]  Seg;
  logic [5:0]  Dig_Sel;
  logic        Busy;
  logic        Valid;

  modport master (output Finish, Result, input Seg, Dig_Sel, Busy, Valid);
  modport slave  (input Finish, Result, output Seg, Dig_Sel, Busy, Valid);
endinterface

// File: rtl/result_bcd_display.sv
// Captures Result on Finish, double-dabble converts it (display updates 17 cycles after capture) and
// scans a 6-digit active-low display; never stalls the core. SIGNED_RESULT_EN selects two's-complement display.
module result_bcd_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                 Sysclk,
  input  logic                 Rst,
  result_bcd_display_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_MINUS = 7'h3F;
  localparam logic [19:0] SCAN_MAX  = 20'(SCAN_DIV - 1);

  state_t      r_state, w_next;
  logic [15:0] r_val;
  logic [23:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_neg;
  logic        r_valid;
  logic [6:0]  r_code [6];
  logic [19:0] r_scan;
  logic [2:0]  r_idx;

  logic [23:0] w_adj;
  logic [39:0] w_shl;
  logic [2:0]  w_msd;
  logic [6:0]  w_disp [6];
  logic [15:0] w_mag;
  logic        w_neg;

  function automatic logic [6:0] seg7_code(input logic [3:0] d);
    case (d)
      4'd0:    seg7_code = 7'h40;
      4'd1:    seg7_code = 7'h79;
      4'd2:    seg7_code = 7'h24;
      4'd3:    seg7_code = 7'h30;
      4'd4:    seg7_code = 7'h19;
      4'd5:    seg7_code = 7'h12;
      4'd6:    seg7_code = 7'h02;
      4'd7:    seg7_code = 7'h78;
      4'd8:    seg7_code = 7'h00;
      4'd9:    seg7_code = 7'h10;
      default: seg7_code = SEG_BLANK;
    endcase
  endfunction

`ifdef SIGNED_RESULT_EN
  // 8000h negates to itself, which reads correctly as 32768 unsigned.
  assign w_neg = bus.Result[15];
  assign w_mag = w_neg ? (~bus.Result + 16'd1) : bus.Result;
`else
  assign w_neg = 1'b0;
  assign w_mag = bus.Result;
`endif

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 6; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_shl = {w_adj, r_val} << 1;

  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = 3'(i);
    end
  end

  // Minus sits one digit left of the MSD; magnitude never exceeds 5 digits so it always fits.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_disp[i] = SEG_BLANK;
      if (3'(i) <= w_msd) w_disp[i] = seg7_code(r_bcd[4*i +: 4]);
      else if (r_neg && (3'(i) == w_msd + 3'd1)) w_disp[i] = SEG_MINUS;
    end
  end

  always_ff @(posedge Sysclk or posedge Rst) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.Finish) begin
      w_next = CONV;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        CONV:    w_next = (r_cnt == 4'd15) ? LOAD : CONV;
        LOAD:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // A new Finish always wins over a LOAD in progress, so aborted values never reach the display.
  always_ff @(posedge Sysclk or posedge Rst) begin
    if (Rst) begin
      r_val   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < 6; i++) r_code[i] <= SEG_BLANK;
    end else if (bus.Finish) begin
      r_val <= w_mag;
      r_neg <= w_neg;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (r_state == CONV) begin
      {r_bcd, r_val} <= w_shl;
      r_cnt          <= r_cnt + 4'd1;
    end else if (r_state == LOAD) begin
      for (int i = 0; i < 6; i++) r_code[i] <= w_disp[i];
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge Sysclk or posedge Rst) begin
    if (Rst) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCAN_MAX) begin
      r_scan <= '0;
      r_idx  <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_scan <= r_scan + 20'd1;
    end
  end

  assign bus.Seg     = {1'b1, r_code[r_idx]};
  assign bus.Dig_Sel = ~(6'b000001 << r_idx);
  assign bus.Busy    = (r_state != IDLE);
  assign bus.Valid   = r_valid;
endmodule

// File: tb/tb_result_bcd_display.sv
// Randomized self-checking bench for result_bcd_display against an arithmetic decimal-display model.
module tb_result_bcd_display;
  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   viol   = 0;
  bit   mon_en = 0;
  logic [7:0] obs_seg [6];

  result_bcd_display_if bus ();

  result_bcd_display #(.SCAN_DIV(4)) dut (
    .Sysclk (clk),
    .Rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected Seg for digit position i when value v is shown.
  function automatic logic [7:0] model_seg(input int v, input int i);
    int mag, nd, t, p;
    bit neg;
    mag = v;
    neg = 0;
`ifdef SIGNED_RESULT_EN
    if (v >= 32768) begin
      mag = 65536 - v;
      neg = 1;
    end
`endif
    nd = 1;
    t  = mag / 10;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (i < nd)             return {1'b1, digit_code((mag / p) % 10)};
    else if (neg && i == nd) return 8'hBF;
    else                    return 8'hFF;
  endfunction

  always @(negedge clk) begin
    if (mon_en && bus.Dig_Sel == 6'b111011 && bus.Seg != 8'hFF) viol++;
  end

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic pulse(input logic [15:0] v);
    bus.Finish = 1'b1;
    bus.Result = v;
    @(posedge clk);
    @(negedge clk);
    bus.Finish = 1'b0;
  endtask

  task automatic read_display();
    bit seen [6];
    int n_seen;
    logic [5:0] m;
    for (int i = 0; i < 6; i++) seen[i] = 0;
    n_seen = 0;
    for (int c = 0; c < 60 && n_seen < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        m = ~(6'b000001 << i);
        if (bus.Dig_Sel == m && !seen[i]) begin
          seen[i]    = 1;
          obs_seg[i] = bus.Seg;
          n_seen++;
        end
      end
    end
    if (n_seen != 6) check("scan_timeout", n_seen, 6);
  endtask

  task automatic finish_conv(input logic [15:0] v, input string tag);
    int busy_cnt;
    busy_cnt = 0;
    for (int c = 0; c < 40 && bus.Busy; c++) begin
      busy_cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, busy_cnt, 17);
    check({tag, "_valid"}, bus.Valid, 1);
    read_display();
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_dig%0d", tag, i), obs_seg[i], model_seg(int'(v), i));
  endtask

  task automatic run_conv(input logic [15:0] v, input string tag);
    pulse(v);
    finish_conv(v, tag);
  endtask

  initial begin
    logic [5:0]  e_sel;
    logic [15:0] dir [11];
    logic [15:0] rv;
    rst        = 1'b1;
    bus.Finish = 1'b0;
    bus.Result = '0;
    repeat (3) @(negedge clk);
    check("rst_seg",   bus.Seg,     8'hFF);
    check("rst_digsel", bus.Dig_Sel, 6'h3E);
    check("rst_busy",  bus.Busy,    0);
    check("rst_valid", bus.Valid,   0);
    rst = 1'b0;
    for (int k = 0; k < 28; k++) begin
      #1;
      e_sel = ~(6'b000001 << ((k / 4) % 6));
      check($sformatf("scan_step%0d", k), bus.Dig_Sel, e_sel);
      @(negedge clk);
    end

    run_conv(16'd12345, "typ12345");
    run_conv(16'd0, "zero");

    mon_en = 1;
    pulse(16'd100);
    repeat (7) @(negedge clk);
    run_conv(16'd7, "restart_e8");
    pulse(16'd300);
    repeat (16) @(negedge clk);
    run_conv(16'd8, "restart_e17");
    mon_en = 0;
    check("no_aborted_display", viol, 0);

    dir[0] = 16'hFFFF; dir[1] = 16'h8000; dir[2] = 16'h7FFF; dir[3] = 16'd9;
    dir[4] = 16'd10;   dir[5] = 16'd99;   dir[6] = 16'd100;  dir[7] = 16'd9999;
    dir[8] = 16'd10000; dir[9] = 16'd1;   dir[10] = 16'hFF85;
    for (int j = 0; j < 11; j++) run_conv(dir[j], $sformatf("dir%0h", dir[j]));

    for (int j = 0; j < 16; j++) begin
      rv = 16'($urandom_range(0, 65535));
      run_conv(rv, $sformatf("rnd%0h", rv));
    end

    // Back-to-back pulses: only the last one is displayed.
    bus.Finish = 1'b1;
    bus.Result = 16'd4321;
    @(posedge clk); @(negedge clk);
    bus.Result = 16'd2468;
    @(posedge clk); @(negedge clk);
    bus.Finish = 1'b0;
    finish_conv(16'd2468, "b2b");

    pulse(16'd1234);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_seg",    bus.Seg,     8'hFF);
    check("mid_rst_digsel", bus.Dig_Sel, 6'h3E);
    check("mid_rst_busy",   bus.Busy,    0);
    check("mid_rst_valid",  bus.Valid,   0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_valid", bus.Valid, 0);
    check("post_rst_busy",  bus.Busy,  0);
    check("post_rst_seg",   bus.Seg,   8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
